// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module      : dmem_arbiter_if
// Description : CPU / DMA request ports and SRAM pin bundle for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              sram_cen;
    logic              sram_wen;
    logic              sram_oen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    // Requesters plus SRAM macro side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  sram_cen, sram_wen, sram_oen, sram_a, sram_d,
        output sram_q
    );

    // The arbiter.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output sram_cen, sram_wen, sram_oen, sram_a, sram_d,
        input  sram_q
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester (CPU/DMA) arbiter for the single-port data SRAM.
//               Optional macro DMEM_ARB_RR_EN selects round-robin tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int MAX_CONSEC = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int              CNT_W = 4;
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CONSEC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } owner_t;

    owner_t            r_state;
    owner_t            w_state_nxt;
    owner_t            r_rd_owner;
    owner_t            w_rd_owner_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              w_dma_wins;
    logic              w_cpu_gnt;
    logic              w_dma_gnt;
    logic              w_any_gnt;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    logic [ADDR_W-1:0] r_sram_a;
    logic [DATA_W-1:0] r_sram_d;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    // Grants are masked by rst_n so nothing reaches the SRAM while in reset.
    always_comb begin
        w_dma_wins = 1'b0;
`ifdef DMEM_ARB_RR_EN
        w_dma_wins = (r_state == ST_CPU);
`else
        w_dma_wins = (r_cnt == C_MAX);
`endif
        w_cpu_gnt = rst_n & bus.cpu_req & ~(bus.dma_req & w_dma_wins);
        w_dma_gnt = rst_n & bus.dma_req & ~w_cpu_gnt;
        w_any_gnt = w_cpu_gnt | w_dma_gnt;
    end

    always_comb begin
        w_we           = 1'b0;
        w_addr         = r_sram_a;
        w_wdata        = r_sram_d;
        w_state_nxt    = ST_IDLE;
        w_rd_owner_nxt = ST_IDLE;
        w_cnt_nxt      = '0;

        if (w_cpu_gnt) begin
            w_we        = bus.cpu_we;
            w_addr      = bus.cpu_addr;
            w_wdata     = bus.cpu_wdata;
            w_state_nxt = ST_CPU;
            if (!bus.cpu_we) w_rd_owner_nxt = ST_CPU;
        end else if (w_dma_gnt) begin
            w_we        = bus.dma_we;
            w_addr      = bus.dma_addr;
            w_wdata     = bus.dma_wdata;
            w_state_nxt = ST_DMA;
            if (!bus.dma_we) w_rd_owner_nxt = ST_DMA;
        end

`ifndef DMEM_ARB_RR_EN
        if (bus.dma_req && !w_dma_gnt) begin
            w_cnt_nxt = r_cnt;
            if (w_cpu_gnt && (r_cnt != C_MAX)) w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_owner  <= ST_IDLE;
            r_cnt       <= '0;
            r_sram_a    <= '0;
            r_sram_d    <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_owner <= w_rd_owner_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_any_gnt) begin
                r_sram_a <= w_addr;
                r_sram_d <= w_wdata;
            end
            if (r_rd_owner == ST_CPU) r_cpu_rdata <= bus.sram_q;
            if (r_rd_owner == ST_DMA) r_dma_rdata <= bus.sram_q;
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dma_gnt    = w_dma_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt;

    assign bus.sram_cen   = ~w_any_gnt;
    assign bus.sram_wen   = w_any_gnt ? ~w_we : 1'b1;
    assign bus.sram_oen   = w_any_gnt ? w_we  : 1'b1;
    assign bus.sram_a     = w_addr;
    assign bus.sram_d     = w_wdata;

    // SRAM output is valid in the cycle after the read, so rdata passes it straight through.
    assign bus.cpu_rvalid = (r_rd_owner == ST_CPU);
    assign bus.dma_rvalid = (r_rd_owner == ST_DMA);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.sram_q : r_cpu_rdata;
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.sram_q : r_dma_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_CONSEC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:127];
    logic [31:0] q_r = 32'h0;
    logic        pl  = 1'b1;
    assign bus.sram_q = q_r;

    always @(posedge clk) begin
        if (pl) begin
            mem[5] <= 32'hDEADBEEF;
            for (int k = 0; k < 10; k++) begin
                mem[32 + k] <= 32'hA000_0000 + 32'(k);
                mem[48 + k] <= 32'hB000_0000 + 32'(k);
            end
        end else if (!bus.sram_cen) begin
            if (!bus.sram_wen) mem[bus.sram_a] <= bus.sram_d;
            else               q_r <= mem[bus.sram_a];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    endtask

    function automatic bit dma_turn(input int k);
`ifdef DMEM_ARB_RR_EN
        return (k % 2) == 1;
`else
        return (k % 5) == 4;
`endif
    endfunction

    bit prev_dma;
    int prev_k;

    initial begin
        drive_idle();
        step();
        pl = 1'b0;
        mid();
        chk("rst_cpu_gnt",   bus.cpu_gnt,    0);
        chk("rst_dma_gnt",   bus.dma_gnt,    0);
        chk("rst_rvalid",    {bus.cpu_rvalid, bus.dma_rvalid}, 0);
        chk("rst_rdata",     {bus.cpu_rdata, bus.dma_rdata}, 0);
        chk("rst_ctl",       {bus.sram_cen, bus.sram_wen, bus.sram_oen}, 3'b111);
        chk("rst_a_d",       {bus.sram_a, bus.sram_d}, 0);
        step();
        rst_n = 1'b1;

        // CPU read of address 5
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h05;
        mid();
        chk("crd_gnt",   {bus.cpu_gnt, bus.dma_gnt, bus.cpu_stall}, 3'b100);
        chk("crd_ctl",   {bus.sram_cen, bus.sram_wen, bus.sram_oen}, 3'b010);
        chk("crd_addr",  bus.sram_a, 7'h05);
        step();
        bus.cpu_req = 1'b0;
        mid();
        chk("crd_rvalid", bus.cpu_rvalid, 1);
        chk("crd_rdata",  bus.cpu_rdata, 32'hDEADBEEF);
        chk("crd_cen_off", bus.sram_cen, 1);
        step();
        mid();
        chk("crd_rvalid_end", bus.cpu_rvalid, 0);
        chk("crd_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
        chk("crd_a_hold",     bus.sram_a, 7'h05);

        // DMA write then read of address 0x10
        step();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'h10; bus.dma_wdata = 32'h12345678;
        mid();
        chk("dwr_gnt",  {bus.dma_gnt, bus.cpu_gnt}, 2'b10);
        chk("dwr_ctl",  {bus.sram_cen, bus.sram_wen, bus.sram_oen}, 3'b001);
        chk("dwr_a_d",  {bus.sram_a, bus.sram_d}, {7'h10, 32'h12345678});
        step();
        bus.dma_we = 1'b0;
        mid();
        chk("dwr_no_rvalid", {bus.dma_rvalid, bus.cpu_rvalid}, 0);
        chk("drd_ctl",  {bus.dma_gnt, bus.sram_cen, bus.sram_wen, bus.sram_oen}, 4'b1010);
        step();
        bus.dma_req = 1'b0;
        mid();
        chk("drd_rvalid", {bus.dma_rvalid, bus.cpu_rvalid}, 2'b10);
        chk("drd_rdata",  bus.dma_rdata, 32'h12345678);
        step();

        // Both requesters reading continuously
        prev_dma = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'(32 + k);
            bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 7'(48 + k);
            mid();
            chk($sformatf("str_gnt_%0d", k), {bus.cpu_gnt, bus.dma_gnt},
                dma_turn(k) ? 2'b01 : 2'b10);
            chk($sformatf("str_stall_%0d", k), bus.cpu_stall, dma_turn(k));
            if (k > 0) begin
                chk($sformatf("str_rv_%0d", k), {bus.cpu_rvalid, bus.dma_rvalid},
                    prev_dma ? 2'b01 : 2'b10);
                chk($sformatf("str_rd_%0d", k), prev_dma ? bus.dma_rdata : bus.cpu_rdata,
                    prev_dma ? 32'hB000_0000 + 32'(prev_k) : 32'hA000_0000 + 32'(prev_k));
            end
            prev_dma = dma_turn(k);
            prev_k   = k;
            step();
        end

        // Three idle cycles; last stream grant (k=9) is a DMA read
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("idle_cen_%0d", i), bus.sram_cen, 1);
            chk($sformatf("idle_gnt_%0d", i), {bus.cpu_gnt, bus.dma_gnt}, 0);
            chk($sformatf("idle_rv_%0d", i), {bus.cpu_rvalid, bus.dma_rvalid},
                (i == 0) ? 2'b01 : 2'b00);
            chk($sformatf("idle_crd_hold_%0d", i), bus.cpu_rdata, 32'hA000_0008);
            step();
        end
        chk("owner_idle", 64'(dut.r_state), 0);

        // Reset asserted while a CPU read is outstanding
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h20;
        mid();
        chk("mrst_gnt", bus.cpu_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_gnt_off", {bus.cpu_gnt, bus.dma_gnt}, 0);
        chk("mrst_ctl",     {bus.sram_cen, bus.sram_wen, bus.sram_oen}, 3'b111);
        step();
        chk("mrst_rvalid_in", bus.cpu_rvalid, 0);
        rst_n = 1'b1;
        bus.cpu_req = 1'b0;
        mid();
        chk("mrst_rvalid_out", bus.cpu_rvalid, 0);
        chk("mrst_rdata",      bus.cpu_rdata, 0);
        step();
        bus.cpu_req = 1'b1; bus.cpu_addr = 7'h05;
        mid();
        chk("post_gnt", {bus.cpu_gnt, bus.sram_cen, bus.sram_oen}, 3'b100);
        step();
        bus.cpu_req = 1'b0;
        mid();
        chk("post_rvalid", bus.cpu_rvalid, 1);
        chk("post_rdata",  bus.cpu_rdata, 32'hDEADBEEF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
